direction_step_controller: RTL
==============================

Name: direction_step_controller

Overview:
- Four-direction Moore controller for the playfield position counters.
- Next generation of the single-axis up/down controller: rotates heading among UP/RIGHT/DOWN/LEFT on turn requests and drives both x and y counters.
- Owns its own step-rate divider, so the position counters advance one cell per step pulse.
- Turn requests are edge-detected and buffered, then applied only on step boundaries.

Parameters:
- STEP_DIV, 25_000_000, clock cycles per step, ≥2.
- INIT_DIR, 2'd0, heading after reset: 0=UP, 1=RIGHT, 2=DOWN, 3=LEFT.
- CNT_W, $clog2(STEP_DIV), divider counter width. Localparam, not overridable.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  run/pause. Low freezes the divider.
- turn_right  in  1  level input; a rising edge requests a clockwise rotation.
- turn_left  in  1  level input; a rising edge requests a counter-clockwise rotation.
- dir  out  2  current heading.
- step  out  1  one-cycle pulse per step.
- x_en  out  1  x counter enable; equals step when heading is RIGHT or LEFT.
- x_up  out  1  1 when heading is RIGHT.
- y_en  out  1  y counter enable; equals step when heading is UP or DOWN.
- y_up  out  1  1 when heading is UP.

Behaviour:
- Registers: dir_reg, cnt, step_reg, pending (valid + rotation), tr_q, tl_q (previous input samples).
- Reset state: dir_reg=INIT_DIR, cnt=0, step_reg=0, pending empty, tr_q=tl_q=0.
  - Reset outputs: step=0, x_en=0, y_en=0; x_up/y_up decoded from INIT_DIR.
  - A button held through reset produces an edge on the first cycle after release of rst.
- Outputs are decoded only from registers (Moore). No combinational path from inputs to outputs.
- Edge detect:
  - rise_r = turn_right & ~tr_q; rise_l = turn_left & ~tl_q.
  - rise_r and rise_l in the same cycle: both discarded.
  - A held level yields exactly one request.
- Request capture:
  - First valid request is latched into pending.
  - Further requests while pending is full are discarded (first-wins).
  - Requests are captured regardless of enable.
- Tick: cycle where enable=1 and cnt==STEP_DIV-1. At that edge:
  - cnt <= 0 and step_reg <= 1.
  - If pending is full, dir_reg <= dir_reg ±1 mod 4 (right=+1, left=-1) and pending is cleared.
  - Otherwise, a valid request arriving in the tick cycle is applied directly and not stored.
  - If pending is full and a new request arrives in the same cycle, the new request is discarded.
- Non-tick cycles:
  - step_reg <= 0.
  - cnt increments if enable=1, holds if enable=0.
- Timing:
  - step is high in the cycle after the tick edge, with the updated dir already visible.
  - Worst-case turn latency is STEP_DIV cycles.
  - Direct reversal is impossible; each tick applies at most one 90° rotation.
- Reset asserted mid-operation clears every register immediately. No step pulse is emitted while rst=1.

Optional Feature:
- Macro: DIR_TURN_QUEUE_EN.
- Defined: pending becomes a 2-entry FIFO.
  - Each tick pops one rotation.
  - A third request while the FIFO is full is discarded.
  - Same-cycle pop and push is allowed.
  - A request arriving in the tick cycle with the FIFO empty is applied directly.
- Undefined: single-slot first-wins behaviour as specified above.

Decomposition:
- Shared package dir_pkg:
  - DIR_UP/RIGHT/DOWN/LEFT 2-bit localparams.
  - rot_cw / rot_ccw functions.
  - Output decode function, shared with the existing up/down controller and the position counters.
- Sub-module step_timer: parametrised STEP_DIV divider with enable, emitting the tick strobe. Reused by the food/score timers.

Test Plan:
1. STEP_DIV=4, INIT_DIR=UP, enable=1 from reset release → step at cycles 4, 8, 12; y_en=y_up=1 on each step; x_en never 1.
2. Single-cycle turn_right at cycle 1 → dir stays UP through cycle 3, becomes RIGHT with step at cycle 4, x_en=x_up=1; left pulse later gives RIGHT→UP.
3. Two turn_right edges between ticks → without macro dir goes UP→RIGHT and stays RIGHT; with DIR_TURN_QUEUE_EN it goes RIGHT at the first tick and DOWN at the next.
4. turn_left and turn_right rise in the same cycle → no rotation; dir stays UP over the next 3 ticks.
5. turn_left held high for 10 cycles → exactly one rotation, UP→LEFT; x_en=1, x_up=0 on step.
6. Drop enable at cnt=2 for 5 cycles → no step, cnt holds at 2; re-enable → step one cycle after cnt reaches 3. Assert rst mid-count with pending full → dir=INIT_DIR, cnt=0, pending empty, no step.

Source files
------------

// File: rtl/dir_pkg.sv
// rtl/dir_pkg.sv - shared heading encodings, rotation helpers and axis decode
// Used by the direction controllers and the position counters.
package dir_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef struct packed {
    logic x_en;
    logic x_up;
    logic y_en;
    logic y_up;
  } axis_ctl_t;

  function automatic logic [1:0] rot_cw(input logic [1:0] d);
    return d + 2'd1;
  endfunction

  function automatic logic [1:0] rot_ccw(input logic [1:0] d);
    return d - 2'd1;
  endfunction

  function automatic logic [1:0] rot_apply(input logic [1:0] d, input logic cw);
    return cw ? rot_cw(d) : rot_ccw(d);
  endfunction

  // Enables follow the step pulse on the axis the heading lies on.
  function automatic axis_ctl_t dir_decode(input logic [1:0] d, input logic step);
    axis_ctl_t c;
    c.x_en = step && (d == DIR_RIGHT || d == DIR_LEFT);
    c.x_up = (d == DIR_RIGHT);
    c.y_en = step && (d == DIR_UP || d == DIR_DOWN);
    c.y_up = (d == DIR_UP);
    return c;
  endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - enable-gated clock divider emitting a one-cycle tick strobe
// tick_o is high in the last cycle of each STEP_DIV-cycle period.
module step_timer #(
  parameter int STEP_DIV = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(STEP_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = enable_i && (cnt_q == CNT_W'(STEP_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (tick_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/direction_step_controller.sv
// rtl/direction_step_controller.sv - four-way heading controller with built-in step divider
// DIR_TURN_QUEUE_EN turns the single pending-turn slot into a 2-entry FIFO.
module direction_step_controller
  import dir_pkg::*;
#(
  parameter int         STEP_DIV = 25_000_000,
  parameter logic [1:0] INIT_DIR = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       turn_right,
  input  logic       turn_left,
  output logic [1:0] dir,
  output logic       step,
  output logic       x_en,
  output logic       x_up,
  output logic       y_en,
  output logic       y_up
);

  logic       tick;
  logic       tr_q, tl_q;
  logic       rise_r, rise_l;
  logic       req_v, req_cw;
  logic [1:0] dir_q, dir_d;
  logic       step_q, step_d;
  logic [1:0] pend_cnt_q, pend_cnt_d;
  logic       q0_q, q0_d;
`ifdef DIR_TURN_QUEUE_EN
  logic       q1_q, q1_d;
`endif
  axis_ctl_t  ctl;

  step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .tick_o   (tick)
  );

  // Simultaneous edges on both buttons cancel out.
  assign rise_r = turn_right && !tr_q;
  assign rise_l = turn_left  && !tl_q;
  assign req_v  = rise_r ^ rise_l;
  assign req_cw = rise_r;

  always_comb begin
    dir_d      = dir_q;
    step_d     = tick;
    pend_cnt_d = pend_cnt_q;
    q0_d       = q0_q;
`ifdef DIR_TURN_QUEUE_EN
    q1_d       = q1_q;
`endif
    if (tick) begin
      if (pend_cnt_q != 2'd0) begin
        dir_d      = rot_apply(dir_q, q0_q);
        pend_cnt_d = pend_cnt_q - 2'd1;
`ifdef DIR_TURN_QUEUE_EN
        q0_d       = q1_q;
`endif
      end else if (req_v) begin
        dir_d = rot_apply(dir_q, req_cw);
      end
    end
`ifdef DIR_TURN_QUEUE_EN
    // Push after the pop so a full FIFO can accept a request on a tick.
    if (req_v && !(tick && pend_cnt_q == 2'd0) && pend_cnt_d < 2'd2) begin
      if (pend_cnt_d == 2'd0) begin
        q0_d = req_cw;
      end else begin
        q1_d = req_cw;
      end
      pend_cnt_d = pend_cnt_d + 2'd1;
    end
`else
    if (req_v && !tick && pend_cnt_q == 2'd0) begin
      q0_d       = req_cw;
      pend_cnt_d = 2'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q      <= INIT_DIR;
      step_q     <= 1'b0;
      pend_cnt_q <= 2'd0;
      q0_q       <= 1'b0;
`ifdef DIR_TURN_QUEUE_EN
      q1_q       <= 1'b0;
`endif
      tr_q       <= 1'b0;
      tl_q       <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      step_q     <= step_d;
      pend_cnt_q <= pend_cnt_d;
      q0_q       <= q0_d;
`ifdef DIR_TURN_QUEUE_EN
      q1_q       <= q1_d;
`endif
      tr_q       <= turn_right;
      tl_q       <= turn_left;
    end
  end

  assign ctl  = dir_decode(dir_q, step_q);
  assign dir  = dir_q;
  assign step = step_q;
  assign x_en = ctl.x_en;
  assign x_up = ctl.x_up;
  assign y_en = ctl.y_en;
  assign y_up = ctl.y_up;

endmodule
